audio_pwm_dac: RTL and testbench
================================

# audio_pwm_dac

Output stage directly downstream of the four-channel mixer. Consumes the mixer's 6-bit unsigned `audio_out` sample through a valid/ready handshake and buffers one sample. Drives a single-bit PWM waveform to the board's RC-filtered audio pin, one sample per PWM frame. Repeats the last sample and flags an underrun when the mixer fails to deliver in time.

## Interface
- `SAMPLE_W`, 6: sample width; PWM frame length is 2**SAMPLE_W ticks.
- `DIV`, 1: clocks per PWM tick; legal range 1..1024; 1 means every clock is a tick.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain only.
- `enable`  in  1  high = run; low = silence and hold the frame counter at 0.
- `sample`  in  SAMPLE_W  unsigned mixer sample (0 = silent, 63 = max).
- `sample_valid`  in  1  `sample` is offered.
- `sample_ready`  out  1  the holding register is empty; transfer occurs on `sample_valid && sample_ready`.
- `pwm_out`  out  1  registered PWM output.
- `frame_start`  out  1  one-clock pulse when a new frame begins.
- `underrun`  out  1  one-clock pulse when a frame begins with no buffered sample.

## Operation
- Registers:
  - `hold` / `hold_full`: one-entry buffer.
  - `active`: sample being played.
  - `cnt`: frame position, 0..63.
  - prescaler: 0..DIV-1.
  - `state`: IDLE or RUN.
- `sample_ready = !hold_full`. It is combinational from a register, with no dependence on `sample_valid`.
- Transfer: `hold <= sample`, `hold_full <= 1`.
- Tick: the prescaler reaches DIV-1 while `enable` = 1. On each tick, `cnt` increments mod 64.
- Frame boundary: a tick where `cnt` == 63 wraps to 0.
  - If `hold_full`: `active <= hold`, `hold_full <= 0`, `frame_start` pulses, and IDLE moves to RUN.
  - If not `hold_full` and in RUN: `active` is held, and both `underrun` and `frame_start` pulse.
  - If not `hold_full` and in IDLE: no pulses.
- Duty: `pwm_out <= (state == RUN) && enable && (cnt < active)`. High-time is `active` ticks out of 64; `active` = 0 gives a constant low. Arithmetic is an unsigned SAMPLE_W-bit compare, with no wider intermediate.
- `enable` falling: next clock `cnt` = 0, prescaler = 0, `state` = IDLE, `pwm_out` = 0. `hold` and `hold_full` are retained, and the handshake stays live.
- Startup from IDLE: `cnt` free-runs while `enable` = 1. The first sample loads at the first frame boundary after it is buffered.

## Timing
- Reset values, applied asynchronously:
  - `pwm_out` = 0, `frame_start` = 0, `underrun` = 0.
  - `sample_ready` = 1 (`hold_full` = 0).
  - `cnt` = 0, prescaler = 0, `active` = 0, `state` = IDLE.
- Reset asserted mid-frame discards `hold` and `active` immediately.
- Handshake latency: the transfer completes at edge t. `sample_ready` is low from t until the boundary edge that empties `hold`, then high from that edge onward.
- Boundary and handshake in the same edge:
  - Only possible when `hold` is empty. Underrun rules apply (pulse if RUN).
  - The incoming sample lands in `hold`, not `active`. It plays from the following frame.
- `frame_start` and `underrun` assert for exactly one clock: the clock after the boundary edge.
- `pwm_out` lags `cnt` and `active` by one clock. The first `pwm_out` high of a loaded frame appears one clock after `frame_start` rises, when `active` > 0.
- Frame period is 64·DIV clocks. The mixer must offer one sample per frame to avoid underrun.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W` = 6.
  - `typedef logic [SAMPLE_W-1:0] sample_t`; the mixer output and this block both use it.
  - `typedef enum logic {IDLE, RUN} dac_state_t`.
- Sub-module `tick_div` (parameter DIV; ports `clk`, `reset_n`, `enable`, `tick`) holds the prescaler. It clears when `enable` is low. With DIV = 1, `tick` equals `enable`.
- Everything else lives in `audio_pwm_dac`.

## Test plan
- Reset: assert `reset_n` = 0 mid-frame with `hold_full` = 1 → all outputs at their reset values immediately; `sample_ready` = 1 one clock after release.
- Basic duty (DIV = 1, `enable` = 1): offer sample 16, then keep 16 buffered every frame → after the first `frame_start`, `pwm_out` is high 16 clocks and low 48 per 64-clock frame; no `underrun`.
- Extremes: samples 0 then 63 → `pwm_out` low for all 64 clocks, then high 63 of 64 clocks; `frame_start` every 64 clocks.
- Backpressure: `sample_valid` held high with values 10, 20, 30 → each value is accepted once per frame, `sample_ready` stays low between boundaries, and duties 10, 20, 30 play in order.
- Underrun: load 40, then withhold samples for 2 frames → `underrun` pulses at both boundaries, duty stays 40. Offering 5 on a boundary edge → `underrun` pulses and 5 plays the next frame.
- Enable drop (DIV = 4): drop `enable` mid-frame with 50 buffered → `pwm_out` = 0 and `cnt` = 0 next clock. Re-enable → 50 loads at the first boundary, 256 clocks later.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: the mixer output and the PWM DAC both use sample_t.
package audio_pkg;

  localparam int SAMPLE_W = 6;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dac_state_t;

  // Last frame position; the tick that leaves it is the frame boundary.
  localparam sample_t CNT_LAST = {SAMPLE_W{1'b1}};

endpackage

// File: rtl/audio_pwm_dac_if.sv
// Sample handshake between the mixer (master) and the PWM DAC (slave).
interface audio_pwm_dac_if;
  import audio_pkg::*;

  sample_t sample;
  logic    sample_valid;
  logic    sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/audio_pwm_dac_tick_div.sv
// PWM tick prescaler: one tick every DIV enabled clocks, cleared while disabled.
module tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC_LOAD = PW'(DIV - 1);

  logic [PW-1:0] pre_d, pre_q;

  // Down-counter; terminal count 0 is the tick, so DIV=1 ticks on every enabled clock.
  always_comb begin
    pre_d = pre_q;
    if (!enable || (pre_q == '0)) begin
      pre_d = TC_LOAD;
    end else begin
      pre_d = pre_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= TC_LOAD;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = enable && (pre_q == '0);

endmodule

// File: rtl/audio_pwm_dac.sv
// One-sample buffered PWM audio DAC; repeats the last sample and flags underrun
// when the mixer misses a frame.
//   state | meaning
//   IDLE  | no sample loaded since enable/reset; output silent, no pulses
//   RUN   | playing active; boundaries without a buffered sample underrun
module audio_pwm_dac
  import audio_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  audio_pwm_dac_if.slave  snk,
  output logic            pwm_out,
  output logic            frame_start,
  output logic            underrun
);

  logic tick;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  sample_t    hold_d, hold_q;
  logic       hold_full_d, hold_full_q;
  sample_t    active_d, active_q;
  sample_t    cnt_d, cnt_q;
  dac_state_t state_d, state_q;
  logic       pwm_d, pwm_q;
  logic       frame_start_d, frame_start_q;
  logic       underrun_d, underrun_q;

  logic transfer;
  logic boundary;

  assign transfer = snk.sample_valid && !hold_full_q;
  assign boundary = tick && (cnt_q == CNT_LAST);

  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    active_d      = active_q;
    cnt_d         = cnt_q;
    state_d       = state_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    pwm_d         = (state_q == RUN) && enable && (cnt_q < active_q);

    if (!enable) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (boundary) begin
      if (hold_full_q) begin
        active_d      = hold_q;
        hold_full_d   = 1'b0;
        frame_start_d = 1'b1;
        state_d       = RUN;
      end else if (state_q == RUN) begin
        frame_start_d = 1'b1;
        underrun_d    = 1'b1;
      end
    end

    // Only possible with hold empty, so it never races the boundary load above.
    if (transfer) begin
      hold_d      = snk.sample;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      active_q      <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      active_q      <= active_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign snk.sample_ready = !hold_full_q;
  assign pwm_out          = pwm_q;
  assign frame_start      = frame_start_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Bench for audio_pwm_dac: two instances (DIV=1, DIV=4) against a time-based reference model.
module tb_audio_pwm_dac;
  import audio_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    en;
  logic    valid;
  sample_t smp;
  logic    pwm_a, fs_a, ur_a, pwm_b, fs_b, ur_b;

  audio_pwm_dac_if if_a ();
  audio_pwm_dac_if if_b ();

  assign if_a.sample       = smp;
  assign if_a.sample_valid = valid;
  assign if_b.sample       = smp;
  assign if_b.sample_valid = valid;

  audio_pwm_dac #(.DIV(1)) dut_a (
    .clk(clk), .reset_n(rst_n), .enable(en), .snk(if_a),
    .pwm_out(pwm_a), .frame_start(fs_a), .underrun(ur_a)
  );

  audio_pwm_dac #(.DIV(4)) dut_b (
    .clk(clk), .reset_n(rst_n), .enable(en), .snk(if_b),
    .pwm_out(pwm_b), .frame_start(fs_b), .underrun(ur_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position derived from the count of enabled clocks.
  int m_div [2] = '{1, 4};
  int m_clks[2];
  bit m_hf  [2];
  int m_hold[2];
  int m_act [2];
  bit m_run [2];
  bit e_pwm [2];
  bit e_fs  [2];
  bit e_ur  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_clks[k] = 0; m_hf[k] = 0; m_hold[k] = 0; m_act[k] = 0; m_run[k] = 0;
      e_pwm[k] = 0; e_fs[k] = 0; e_ur[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int pos;
    bit tick, acc;
    pos  = (m_clks[k] / m_div[k]) % 64;
    tick = en && ((m_clks[k] % m_div[k]) == m_div[k] - 1);
    acc  = valid && !m_hf[k];
    e_pwm[k] = m_run[k] && en && (pos < m_act[k]);
    e_fs[k] = 0;
    e_ur[k] = 0;
    if (!en) begin
      m_clks[k] = 0;
      m_run[k]  = 0;
    end else begin
      if (tick && pos == 63) begin
        if (m_hf[k]) begin
          m_act[k] = m_hold[k]; m_hf[k] = 0; m_run[k] = 1; e_fs[k] = 1;
        end else if (m_run[k]) begin
          e_fs[k] = 1; e_ur[k] = 1;
        end
      end
      m_clks[k] = (m_clks[k] + 1) % (64 * m_div[k]);
    end
    if (acc) begin
      m_hold[k] = int'(smp);
      m_hf[k]   = 1;
    end
  endtask

  // Frame monitor for instance A: high-count and length of each completed frame.
  int hi_a = 0, per_a = 0, ur_cnt_a = 0;
  int dq_a[$];
  int pq_a[$];

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end else begin
      model_reset();
    end
    @(negedge clk);
    check_eq("pwm_a", pwm_a, e_pwm[0]);
    check_eq("fs_a",  fs_a,  e_fs[0]);
    check_eq("ur_a",  ur_a,  e_ur[0]);
    check_eq("rdy_a", if_a.sample_ready, !m_hf[0]);
    check_eq("pwm_b", pwm_b, e_pwm[1]);
    check_eq("fs_b",  fs_b,  e_fs[1]);
    check_eq("ur_b",  ur_b,  e_ur[1]);
    check_eq("rdy_b", if_b.sample_ready, !m_hf[1]);
    if (fs_a) begin
      dq_a.push_back(hi_a);
      pq_a.push_back(per_a);
      hi_a = 0;
      per_a = 0;
    end
    hi_a     += int'(pwm_a);
    per_a    += 1;
    ur_cnt_a += int'(ur_a);
  endtask

  task automatic wait_fs(input int k, input int bound);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!((k == 0) ? fs_a : fs_b) && n < bound);
    if (!((k == 0) ? fs_a : fs_b)) check_eq("fs_timeout", 0, 1);
  endtask

  initial begin
    int base, ur0, n, ones;
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; smp = '0;
    model_reset();
    repeat (3) cyc();
    check_eq("rst_rdy_a", if_a.sample_ready, 1);
    check_eq("rst_pwm_a", pwm_a, 0);
    rst_n = 1'b1;
    cyc();
    check_eq("rel_rdy_b", if_b.sample_ready, 1);

    // Basic duty 16
    en = 1'b1; valid = 1'b1; smp = 6'd16;
    repeat (2) wait_fs(0, 200);
    base = dq_a.size(); ur0 = ur_cnt_a;
    repeat (3) wait_fs(0, 200);
    for (int i = 0; i < 3; i++) check_eq("duty16", qget(dq_a, base + i), 16);
    check_eq("period16", qget(pq_a, base), 64);
    check_eq("no_underrun", ur_cnt_a - ur0, 0);

    // Extremes 0 then 63
    smp = 6'd0;
    n = 0;
    while (!if_a.sample_ready && n < 200) begin cyc(); n++; end
    cyc();
    smp = 6'd63;
    wait_fs(0, 200);
    base = dq_a.size();
    wait_fs(0, 200);
    wait_fs(0, 200);
    check_eq("duty0", qget(dq_a, base), 0);
    check_eq("duty63", qget(dq_a, base + 1), 63);
    check_eq("period_ext0", qget(pq_a, base), 64);
    check_eq("period_ext1", qget(pq_a, base + 1), 64);

    // Backpressure 10, 20, 30 with valid held high
    smp = 6'd10;
    cyc();
    smp = 6'd20;
    wait_fs(0, 200);
    base = dq_a.size();
    cyc();
    check_eq("bp_rdy_low", if_a.sample_ready, 0);
    smp = 6'd30;
    wait_fs(0, 200);
    cyc();
    valid = 1'b0;
    wait_fs(0, 200);
    wait_fs(0, 200);
    check_eq("bp_duty10", qget(dq_a, base), 10);
    check_eq("bp_duty20", qget(dq_a, base + 1), 20);
    check_eq("bp_duty30", qget(dq_a, base + 2), 30);

    // Underrun: load 40, withhold two frames
    valid = 1'b1; smp = 6'd40;
    cyc();
    valid = 1'b0;
    wait_fs(0, 200);
    base = dq_a.size(); ur0 = ur_cnt_a;
    wait_fs(0, 200);
    wait_fs(0, 200);
    check_eq("ur_count", ur_cnt_a - ur0, 2);
    check_eq("ur_duty40a", qget(dq_a, base), 40);
    check_eq("ur_duty40b", qget(dq_a, base + 1), 40);

    // Offer 5 exactly on a boundary edge
    repeat (63) cyc();
    valid = 1'b1; smp = 6'd5;
    cyc();
    check_eq("edge_fs", fs_a, 1);
    check_eq("edge_ur", ur_a, 1);
    valid = 1'b0;
    base = dq_a.size();
    wait_fs(0, 200);
    wait_fs(0, 200);
    check_eq("edge_duty40", qget(dq_a, base), 40);
    check_eq("edge_duty5", qget(dq_a, base + 1), 5);

    // Enable drop on the DIV=4 instance with 50 buffered
    wait_fs(1, 600);
    valid = 1'b1; smp = 6'd50;
    cyc();
    valid = 1'b0;
    check_eq("drop_rdy_b", if_b.sample_ready, 0);
    repeat ($urandom_range(5, 100)) cyc();
    en = 1'b0;
    cyc();
    check_eq("drop_pwm_b", pwm_b, 0);
    repeat (20) cyc();
    check_eq("drop_hold_b", if_b.sample_ready, 0);
    en = 1'b1;
    n = 0; ones = 0;
    while (n < 600) begin
      cyc();
      n++;
      ones += int'(pwm_b);
      if (fs_b) break;
    end
    check_eq("reen_latency", n, 256);
    check_eq("reen_idle_pwm", ones, 0);
    ones = 0;
    repeat (256) begin cyc(); ones += int'(pwm_b); end
    check_eq("reen_duty50", ones, 200);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (en) en = ($urandom_range(0, 149) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      valid = ($urandom_range(0, 15) == 0);
      smp   = sample_t'($urandom_range(0, 63));
      cyc();
    end
    en = 1'b1;

    // Asynchronous reset mid-frame with the buffer full
    valid = 1'b1; smp = 6'd33;
    n = 0;
    while (if_a.sample_ready && n < 200) begin cyc(); n++; end
    repeat (10) cyc();
    check_eq("pre_rst_full", if_a.sample_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pwm_a", pwm_a, 0);
    check_eq("arst_fs_a", fs_a, 0);
    check_eq("arst_ur_a", ur_a, 0);
    check_eq("arst_rdy_a", if_a.sample_ready, 1);
    check_eq("arst_rdy_b", if_b.sample_ready, 1);
    valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check_eq("post_rst_rdy", if_a.sample_ready, 1);
    valid = 1'b1; smp = 6'd20;
    repeat (300) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
